// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: stereo PCM sample buffer between the monitor-link
// op decoder and the I2S sender, with 22 kHz doubling and host pacing.
//
// Ports:
//   mon_clk, hw_reset_n        clock / async active-low reset
//   sample_valid, sample_data  push strobe and {left,right} sample
//   audio_start, audio_end     stream begin / end pulses
//   half_rate                  22 kHz mode, latched on audio_start
//   frame_tick                 one pulse per I2S LR frame
//   pcm_out, pcm_valid         registered frame sample and update pulse
//   request_mode               host should keep sending samples
//   request_underrun           frame found the FIFO empty while playing
//   request_tick               ask the host for one more sample
//   level, overflow            occupancy and sticky drop flag
module audio_sample_fifo #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int LOW_WATER = 8
) (
    input  logic          mon_clk,
    input  logic          hw_reset_n,
    input  logic          sample_valid,
    input  logic [31:0]   sample_data,
    input  logic          audio_start,
    input  logic          audio_end,
    input  logic          half_rate,
    input  logic          frame_tick,
    output logic [31:0]   pcm_out,
    output logic          pcm_valid,
    output logic          request_mode,
    output logic          request_underrun,
    output logic          request_tick,
    output logic [AW:0]   level,
    output logic          overflow
);

    typedef enum logic [1:0] {IDLE, PRIME, PLAY, DRAIN} state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LOW_LVL  = (AW+1)'(LOW_WATER);

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_next;
    logic          hr_q;
    logic          phase;

    logic active;
    logic empty;
    logic full;
    logic tick_play;
    logic repeat_tick;
    logic do_pop;
    logic do_push;
    logic drop;

    assign level  = cnt;
    assign active = (state != IDLE);
    assign empty  = (cnt == '0);
    assign full   = (cnt == FULL_LVL);

    // audio_start flushes everything, so it masks ticks and pushes
    assign tick_play   = frame_tick && !audio_start &&
                         (state == PLAY || state == DRAIN);
    assign repeat_tick = tick_play && hr_q && phase;
    assign do_pop      = tick_play && !repeat_tick && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push     = sample_valid && active && !audio_start &&
                         (!full || do_pop);
    assign drop        = sample_valid && active && !audio_start &&
                         full && !do_pop;

    assign request_mode = (state == PRIME) ||
                          (state == PLAY && cnt < LOW_LVL);

    always_comb begin
        cnt_next = cnt;
        if (do_push && !do_pop)
            cnt_next = cnt + 1'b1;
        else if (!do_push && do_pop)
            cnt_next = cnt - 1'b1;
    end

    always_ff @(posedge mon_clk) begin
        if (do_push)
            mem[wr_ptr] <= sample_data;
    end

    always_ff @(posedge mon_clk or negedge hw_reset_n) begin
        if (!hw_reset_n) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            cnt              <= '0;
            hr_q             <= 1'b0;
            phase            <= 1'b0;
            overflow         <= 1'b0;
            pcm_out          <= '0;
            pcm_valid        <= 1'b0;
            request_tick     <= 1'b0;
            request_underrun <= 1'b0;
        end else begin
            pcm_valid        <= 1'b0;
            request_tick     <= 1'b0;
            request_underrun <= 1'b0;
            if (audio_start) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                cnt      <= '0;
                overflow <= 1'b0;
                phase    <= 1'b0;
                hr_q     <= half_rate;
                state    <= PRIME;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (drop)
                    overflow <= 1'b1;
                cnt <= cnt_next;
                unique case (state)
                    IDLE: begin
                    end
                    PRIME: begin
                        // still priming: frames play silence
                        if (frame_tick) begin
                            pcm_out   <= '0;
                            pcm_valid <= 1'b1;
                        end
                        if (audio_end)
                            state <= DRAIN;
                        else if (cnt >= LOW_LVL)
                            state <= PLAY;
                    end
                    PLAY, DRAIN: begin
                        if (frame_tick) begin
                            pcm_valid <= 1'b1;
                            if (repeat_tick) begin
                                phase <= 1'b0;
                            end else if (!empty) begin
                                pcm_out <= mem[rd_ptr];
                                phase   <= hr_q;
                                if (state == PLAY && cnt_next < LOW_LVL)
                                    request_tick <= 1'b1;
                            end else begin
                                pcm_out <= '0;
                                phase   <= 1'b0;
                                if (state == PLAY)
                                    request_underrun <= 1'b1;
                                else
                                    state <= IDLE;
                            end
                        end
                        if (state == PLAY && audio_end)
                            state <= DRAIN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb_audio_sample_fifo: directed bench for audio_sample_fifo.
// Expected values are hand-computed per step.
module tb_audio_sample_fifo;

    logic        mon_clk = 1'b0;
    logic        hw_reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [31:0] sample_data = '0;
    logic        audio_start = 1'b0;
    logic        audio_end = 1'b0;
    logic        half_rate = 1'b0;
    logic        frame_tick = 1'b0;
    logic [31:0] pcm_out;
    logic        pcm_valid;
    logic        request_mode;
    logic        request_underrun;
    logic        request_tick;
    logic [4:0]  level;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    audio_sample_fifo dut (
        .mon_clk          (mon_clk),
        .hw_reset_n       (hw_reset_n),
        .sample_valid     (sample_valid),
        .sample_data      (sample_data),
        .audio_start      (audio_start),
        .audio_end        (audio_end),
        .half_rate        (half_rate),
        .frame_tick       (frame_tick),
        .pcm_out          (pcm_out),
        .pcm_valid        (pcm_valid),
        .request_mode     (request_mode),
        .request_underrun (request_underrun),
        .request_tick     (request_tick),
        .level            (level),
        .overflow         (overflow)
    );

    always #5 mon_clk = ~mon_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge mon_clk);
        #1;
    endtask

    task automatic start(input logic hr);
        half_rate = hr;
        audio_start = 1'b1;
        cyc();
        audio_start = 1'b0;
        half_rate = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        sample_valid = 1'b1;
        sample_data = d;
        cyc();
        sample_valid = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    logic [31:0] exp_seq [6];

    initial begin
        // reset values
        #2;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_pcm", pcm_out, 32'd0);
        chk("rst_valid", 32'(pcm_valid), 32'd0);
        chk("rst_reqmode", 32'(request_mode), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        #20;
        hw_reset_n = 1'b1;
        cyc();

        // idle ignores pushes and ticks
        push(32'hDEAD_BEEF);
        chk("idle_push", 32'(level), 32'd0);
        tick();
        chk("idle_tick", 32'(pcm_valid), 32'd0);

        // prime and play
        start(1'b0);
        chk("prime_reqmode", 32'(request_mode), 32'd1);
        for (int i = 1; i <= 8; i++)
            push(32'h0001_0001 * i);
        chk("prime_level", 32'(level), 32'd8);
        chk("prime_still", 32'(request_mode), 32'd1);
        cyc();
        chk("play_reqmode", 32'(request_mode), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("p_pcm%0d", i), pcm_out,
                (i <= 8) ? 32'h0001_0001 * i : 32'd0);
            chk($sformatf("p_valid%0d", i), 32'(pcm_valid), 32'd1);
            chk($sformatf("p_rtick%0d", i), 32'(request_tick),
                (i <= 8) ? 32'd1 : 32'd0);
            chk($sformatf("p_urun%0d", i), 32'(request_underrun),
                (i > 8) ? 32'd1 : 32'd0);
            chk($sformatf("p_lvl%0d", i), 32'(level),
                (i <= 8) ? 32'(8 - i) : 32'd0);
        end
        cyc();
        chk("p_valid_drop", 32'(pcm_valid), 32'd0);

        // 22 kHz repeat
        start(1'b1);
        for (int i = 0; i < 8; i++)
            push(32'hAAA0_0000 + 32'(i));
        cyc();
        exp_seq[0] = 32'hAAA0_0000;
        exp_seq[1] = 32'hAAA0_0000;
        exp_seq[2] = 32'hAAA0_0001;
        exp_seq[3] = 32'hAAA0_0001;
        exp_seq[4] = 32'hAAA0_0002;
        exp_seq[5] = 32'hAAA0_0002;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("h_pcm%0d", i), pcm_out, exp_seq[i]);
            chk($sformatf("h_rtick%0d", i), 32'(request_tick),
                (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("h_lvl%0d", i), 32'(level), 32'(7 - i / 2));
        end

        // overflow
        start(1'b0);
        for (int i = 0; i < 17; i++)
            push(32'h0000_0100 + 32'(i));
        chk("o_level", 32'(level), 32'd16);
        chk("o_flag", 32'(overflow), 32'd1);
        start(1'b0);
        chk("o_clr_level", 32'(level), 32'd0);
        chk("o_clr_flag", 32'(overflow), 32'd0);

        // simultaneous push/pop at full
        for (int i = 0; i < 16; i++)
            push(32'h0000_0200 + 32'(i));
        cyc();
        chk("s_full", 32'(level), 32'd16);
        sample_valid = 1'b1;
        sample_data = 32'h0000_02FF;
        frame_tick = 1'b1;
        cyc();
        sample_valid = 1'b0;
        frame_tick = 1'b0;
        chk("s_pcm0", pcm_out, 32'h0000_0200);
        chk("s_level", 32'(level), 32'd16);
        chk("s_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("s_pcm%0d", i), pcm_out,
                (i < 16) ? 32'h0000_0200 + 32'(i) : 32'h0000_02FF);
        end
        chk("s_empty", 32'(level), 32'd0);

        // short stream drain
        start(1'b0);
        push(32'h0000_0011);
        push(32'h0000_0022);
        push(32'h0000_0033);
        audio_end = 1'b1;
        cyc();
        audio_end = 1'b0;
        cyc();
        chk("d_reqmode", 32'(request_mode), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("d_pcm%0d", i), pcm_out,
                (i < 3) ? 32'h0000_0011 * (i + 1) : 32'd0);
            chk($sformatf("d_urun%0d", i), 32'(request_underrun), 32'd0);
            chk($sformatf("d_rtick%0d", i), 32'(request_tick), 32'd0);
            chk($sformatf("d_reqm%0d", i), 32'(request_mode), 32'd0);
        end
        push(32'h0000_0044);
        chk("d_idle", 32'(level), 32'd0);

        // async reset mid-play
        start(1'b0);
        for (int i = 1; i <= 8; i++)
            push(32'h0000_0500 + 32'(i));
        cyc();
        tick();
        tick();
        tick();
        chk("r_level5", 32'(level), 32'd5);
        chk("r_pcm3", pcm_out, 32'h0000_0503);
        sample_data = '0;
        @(negedge mon_clk);
        hw_reset_n = 1'b0;
        #1;
        chk("r_level", 32'(level), 32'd0);
        chk("r_pcm", pcm_out, 32'd0);
        chk("r_reqmode", 32'(request_mode), 32'd0);
        #12;
        hw_reset_n = 1'b1;
        cyc();
        tick();
        chk("r_novalid", 32'(pcm_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
- Buffers 32-bit stereo PCM samples from the monitor-link opcode decoder and releases one per I2S frame to the I2S serialiser.
- Provides 22 kHz sample doubling.
- Generates the sample-request mode, underrun and tick flags that the link sender uses to pace the host.
- Runs entirely in the mon_clk domain; sits between the op decoder and the I2S sender.

Parameters:
DEPTH, 16, FIFO entries (power of two)
AW, 4, address width = log2(DEPTH)
LOW_WATER, 8, level below which more samples are requested; also the priming threshold

Ports:
mon_clk  input  1  monitor-link clock; all logic on rising edge
hw_reset_n  input  1  reset, asynchronous, active-low
sample_valid  input  1  one-cycle push strobe (audio sample packet decoded)
sample_data  input  32  {left[15:0], right[15:0]} two's complement
audio_start  input  1  one-cycle pulse: stream begins
audio_end  input  1  one-cycle pulse: stream ends, drain remaining
half_rate  input  1  22 kHz mode; latched on audio_start
frame_tick  input  1  one-cycle pulse per 44.1 kHz LR frame from I2S side
pcm_out  output  32  current frame sample to I2S sender
pcm_valid  output  1  one-cycle pulse when pcm_out updated
request_mode  output  1  host should send samples
request_underrun  output  1  one-cycle pulse: frame_tick found FIFO empty while PLAY
request_tick  output  1  one-cycle pulse: request another sample
level  output  AW+1  current FIFO occupancy 0..DEPTH
overflow  output  1  sticky: push dropped while full

Behaviour:
- Reset: state IDLE, FIFO empty, level 0, pcm_out 0, every pulse output 0, overflow 0, repeat phase 0, latched half_rate 0.
- State IDLE:
  - Pushes ignored; pcm_out held 0; frame_tick ignored.
  - audio_start -> PRIME.
- Any audio_start, in any state:
  - Flush FIFO (pointers 0, level 0), clear overflow and repeat phase, latch half_rate, go to PRIME next cycle.
  - A sample_valid in the same cycle is discarded.
- State PRIME:
  - Accept pushes; request_mode=1; frame_tick outputs 0 (pcm_valid still pulses).
  - level >= LOW_WATER -> PLAY.
  - audio_end -> DRAIN (stream shorter than threshold still plays).
- State PLAY:
  - request_mode=1 while level < LOW_WATER, else 0.
  - On frame_tick, in this order:
    - half_rate latched and repeat phase=1: re-present previous sample, no pop, phase->0.
    - Else FIFO non-empty: pop head to pcm_out, phase->1 if half_rate else stays 0; request_tick pulses if post-pop level < LOW_WATER.
    - Else empty: pcm_out=0, request_underrun pulses, phase->0, stay in PLAY.
  - audio_end -> DRAIN.
- State DRAIN:
  - request_mode=0; pushes still accepted; no request_tick or request_underrun.
  - frame_tick pops and repeats as in PLAY.
  - frame_tick with FIFO empty and phase=0: pcm_out=0 -> IDLE.
- Timing:
  - pcm_out and pcm_valid are registered, one cycle after frame_tick.
  - request_tick and request_underrun are asserted in that same cycle.
- Push/pop rules:
  - Simultaneous push and pop: both occur, level unchanged, even when full (pop frees the slot).
  - Push when full without a pop: data dropped, overflow set sticky.
  - Pointers wrap modulo DEPTH; level saturates neither way (guarded).
- audio_end and frame_tick in the same cycle: pop is processed, then state -> DRAIN.
- half_rate changes mid-stream are ignored until the next audio_start.
- Reset asserted mid-stream returns everything to reset values immediately (asynchronous); no output pulse is generated.

Test Plan:
- Prime and play: audio_start, push 8 samples 0x00010001..0x00080008, 10 frame_ticks -> state PLAY after the 8th push; pcm_out sequence 1..8 then 0 twice; request_underrun pulses on ticks 9 and 10; request_tick on every pop (level < 8).
- 22 kHz repeat: half_rate=1 at start, push 8 samples A..H, 6 frame_ticks -> pcm_out A,A,B,B,C,C; level goes 8->5.
- Overflow: push 17 samples without ticks -> level 16, overflow=1, 17th lost; next audio_start clears overflow and level to 0.
- Simultaneous push/pop at full: level 16, frame_tick and sample_valid in the same cycle -> level stays 16, overflow stays 0, FIFO order preserved.
- Short stream drain: audio_start, push 3 samples, audio_end, 4 ticks -> pcm_out 3 samples then 0; state IDLE; request_mode 0 throughout DRAIN; no request_underrun.
- Async reset mid-PLAY: hw_reset_n low between clock edges with level 5 -> level 0, pcm_out 0, request_mode 0 immediately; frame_tick after release produces no pcm_valid.
